// File: rtl/grf_scoreboard.sv
// rtl/grf_scoreboard.sv - issue-stage hazard scoreboard for the 32x32 GRF
//
// Tracks in-flight register writers with a busy bit and a countdown until the
// result becomes forwardable, stalls decode when an operand will be late, and
// reports per-operand forwarding state.
//
// Ports:
//   clk, reset           rising-edge clock, synchronous active-high reset
//   issue_*              instruction presented by decode (dest, latency, sources, use times)
//   wb_valid, wb_rd      GRF writeback this cycle (retires the entry)
//   flush                discard every in-flight producer
//   stall                decode must hold; instruction not accepted
//   fwd_rs, fwd_rt       0 = read GRF, 1 = forward from pipeline, 2 = not ready
//   busy_cnt, idle       number of busy registers / no register busy
//   stall_cycles         free-running count of stalled cycles
module grf_scoreboard #(
  parameter int LAT_W  = 3,
  parameter int TUSE_W = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              issue_valid,
  input  logic              issue_we,
  input  logic [4:0]        issue_rd,
  input  logic [LAT_W-1:0]  issue_lat,
  input  logic [4:0]        issue_rs,
  input  logic [4:0]        issue_rt,
  input  logic [TUSE_W-1:0] tuse_rs,
  input  logic [TUSE_W-1:0] tuse_rt,
  input  logic              wb_valid,
  input  logic [4:0]        wb_rd,
  input  logic              flush,
  output logic              stall,
  output logic [1:0]        fwd_rs,
  output logic [1:0]        fwd_rt,
  output logic [5:0]        busy_cnt,
  output logic              idle,
  output logic [31:0]       stall_cycles
);

  // Entry 0 exists only so indexing needs no special case; it is held at zero.
  logic [31:0]      r_busy;
  logic [LAT_W-1:0] r_cnt [32];
  logic [5:0]       r_busy_cnt;
  logic [31:0]      r_stall_cycles;

  logic [31:0]      w_busy_nxt;
  logic [LAT_W-1:0] w_cnt_nxt [32];
  logic [5:0]       w_busy_cnt_nxt;
  logic             w_pend_rs;
  logic             w_pend_rt;
  logic [LAT_W-1:0] w_cnt_rs;
  logic [LAT_W-1:0] w_cnt_rt;
  logic             w_stall;
  logic             w_accept;

  // A same-cycle writeback counts as ready because the GRF bypasses WD to RD.
  assign w_pend_rs = r_busy[issue_rs] && !(wb_valid && wb_rd == issue_rs) && (issue_rs != 5'd0);
  assign w_pend_rt = r_busy[issue_rt] && !(wb_valid && wb_rd == issue_rt) && (issue_rt != 5'd0);
  assign w_cnt_rs  = r_cnt[issue_rs];
  assign w_cnt_rt  = r_cnt[issue_rt];

  // Compare at 32 bits so the latency and use-time widths can differ freely.
  assign w_stall  = issue_valid &&
                    ((w_pend_rs && (32'(w_cnt_rs) > 32'(tuse_rs))) ||
                     (w_pend_rt && (32'(w_cnt_rt) > 32'(tuse_rt))));
  assign w_accept = issue_valid && !w_stall;

  // Later assignments override earlier ones, so the statement order encodes
  // priority: decrement < writeback < issue < flush.
  always_comb begin
    w_busy_nxt = r_busy;
    for (int i = 0; i < 32; i++) begin
      w_cnt_nxt[i] = (r_busy[i] && r_cnt[i] != '0) ? r_cnt[i] - LAT_W'(1) : r_cnt[i];
    end
    if (wb_valid && wb_rd != 5'd0) begin
      w_busy_nxt[wb_rd] = 1'b0;
      w_cnt_nxt[wb_rd]  = '0;
    end
    if (w_accept && issue_we && issue_rd != 5'd0) begin
      w_busy_nxt[issue_rd] = 1'b1;
      w_cnt_nxt[issue_rd]  = issue_lat;
    end
    if (flush) begin
      w_busy_nxt = '0;
      for (int i = 0; i < 32; i++) begin
        w_cnt_nxt[i] = '0;
      end
    end
    w_busy_nxt[0] = 1'b0;
    w_cnt_nxt[0]  = '0;
  end

  always_comb begin
    w_busy_cnt_nxt = '0;
    for (int i = 1; i < 32; i++) begin
      w_busy_cnt_nxt = w_busy_cnt_nxt + 6'(w_busy_nxt[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_busy         <= '0;
      r_busy_cnt     <= '0;
      r_stall_cycles <= '0;
      for (int i = 0; i < 32; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_busy     <= w_busy_nxt;
      r_busy_cnt <= w_busy_cnt_nxt;
      for (int i = 0; i < 32; i++) begin
        r_cnt[i] <= w_cnt_nxt[i];
      end
      // A flush cycle leaves the stall counter alone even if decode was stalled.
      if (w_stall && !flush) begin
        r_stall_cycles <= r_stall_cycles + 32'd1;
      end
    end
  end

  assign stall        = w_stall;
  assign fwd_rs       = !w_pend_rs ? 2'd0 : (w_cnt_rs == '0) ? 2'd1 : 2'd2;
  assign fwd_rt       = !w_pend_rt ? 2'd0 : (w_cnt_rt == '0) ? 2'd1 : 2'd2;
  assign busy_cnt     = r_busy_cnt;
  assign idle         = (r_busy_cnt == 6'd0);
  assign stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_grf_scoreboard.sv
// tb/tb_grf_scoreboard.sv - table-driven scoreboard bench for grf_scoreboard
module tb_grf_scoreboard;

  typedef struct {
    logic        rst, iv, we;
    logic [4:0]  rd;
    logic [2:0]  lat;
    logic [4:0]  rs, rt;
    logic [1:0]  trs, trt;
    logic        wbv;
    logic [4:0]  wbrd;
    logic        fl;
    logic        st;
    logic [1:0]  frs, frt;
    logic [5:0]  bc;
    logic        idl;
    logic [31:0] sc;
  } vec_t;

  typedef struct {
    logic        st;
    logic [1:0]  frs, frt;
    logic [5:0]  bc;
    logic        idl;
    logic [31:0] sc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset, issue_valid, issue_we, wb_valid, flush;
  logic [4:0]  issue_rd, issue_rs, issue_rt, wb_rd;
  logic [2:0]  issue_lat;
  logic [1:0]  tuse_rs, tuse_rt;
  logic        stall, idle;
  logic [1:0]  fwd_rs, fwd_rt;
  logic [5:0]  busy_cnt;
  logic [31:0] stall_cycles;

  int   errors = 0;
  int   checks = 0;
  vec_t vt [29];
  exp_t q [$];

  grf_scoreboard #(.LAT_W(3), .TUSE_W(2)) dut (
    .clk(clk), .reset(reset),
    .issue_valid(issue_valid), .issue_we(issue_we), .issue_rd(issue_rd),
    .issue_lat(issue_lat), .issue_rs(issue_rs), .issue_rt(issue_rt),
    .tuse_rs(tuse_rs), .tuse_rt(tuse_rt),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush),
    .stall(stall), .fwd_rs(fwd_rs), .fwd_rt(fwd_rt),
    .busy_cnt(busy_cnt), .idle(idle), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(
    input logic rst, iv, we, input logic [4:0] rd, input logic [2:0] lat,
    input logic [4:0] rs, rt, input logic [1:0] trs, trt,
    input logic wbv, input logic [4:0] wbrd, input logic fl,
    input logic st, input logic [1:0] frs, frt, input logic [5:0] bc,
    input logic idl, input logic [31:0] sc);
    vec_t v;
    v.rst = rst; v.iv = iv; v.we = we; v.rd = rd; v.lat = lat;
    v.rs = rs; v.rt = rt; v.trs = trs; v.trt = trt;
    v.wbv = wbv; v.wbrd = wbrd; v.fl = fl;
    v.st = st; v.frs = frs; v.frt = frt; v.bc = bc; v.idl = idl; v.sc = sc;
    return v;
  endfunction

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s vec=%0d got=%0d expected=%0d", name, idx, act, exp);
    end
  endtask

  initial begin
    //            rst iv we rd  lat rs  rt  trs trt wbv wbrd fl  st frs frt bc idl sc
    vt[0]  = mk(0, 0, 0, 0,  0,  0,  0,  0,  0,  0,  0,  0,  0, 0, 0, 0, 1, 0);
    vt[1]  = mk(0, 1, 1, 8,  2,  0,  0,  0,  0,  0,  0,  0,  0, 0, 0, 0, 1, 0);
    vt[2]  = mk(0, 1, 0, 0,  0,  8,  0,  0,  0,  0,  0,  0,  1, 2, 0, 1, 0, 0);
    vt[3]  = mk(0, 1, 0, 0,  0,  8,  0,  0,  0,  0,  0,  0,  1, 2, 0, 1, 0, 1);
    vt[4]  = mk(0, 1, 0, 0,  0,  8,  0,  0,  0,  0,  0,  0,  0, 1, 0, 1, 0, 2);
    vt[5]  = mk(0, 0, 0, 0,  0,  8,  0,  0,  0,  1,  8,  0,  0, 0, 0, 1, 0, 2);
    vt[6]  = mk(0, 1, 1, 5,  3,  0,  0,  0,  0,  0,  0,  0,  0, 0, 0, 0, 1, 2);
    vt[7]  = mk(0, 1, 0, 0,  0,  5,  0,  0,  0,  1,  5,  0,  0, 0, 0, 1, 0, 2);
    vt[8]  = mk(0, 0, 0, 0,  0,  5,  0,  0,  0,  0,  0,  0,  0, 0, 0, 0, 1, 2);
    vt[9]  = mk(0, 1, 1, 0,  3,  0,  0,  0,  0,  0,  0,  0,  0, 0, 0, 0, 1, 2);
    vt[10] = mk(0, 1, 0, 0,  0,  0,  0,  0,  0,  0,  0,  0,  0, 0, 0, 0, 1, 2);
    vt[11] = mk(0, 1, 1, 9,  4,  0,  0,  0,  0,  1,  9,  0,  0, 0, 0, 0, 1, 2);
    vt[12] = mk(0, 1, 0, 0,  0,  9,  9,  3,  3,  0,  0,  0,  1, 2, 2, 1, 0, 2);
    vt[13] = mk(0, 1, 0, 0,  0,  9,  9,  3,  3,  0,  0,  0,  0, 2, 2, 1, 0, 3);
    vt[14] = mk(0, 1, 1, 10, 7,  0,  0,  0,  0,  0,  0,  0,  0, 0, 0, 1, 0, 3);
    vt[15] = mk(0, 1, 1, 11, 1,  0,  0,  0,  0,  0,  0,  0,  0, 0, 0, 2, 0, 3);
    vt[16] = mk(0, 1, 1, 12, 2,  0,  0,  0,  0,  1,  9,  1,  0, 0, 0, 3, 0, 3);
    vt[17] = mk(0, 0, 0, 0,  0,  10, 12, 0,  0,  0,  0,  0,  0, 0, 0, 0, 1, 3);
    vt[18] = mk(0, 1, 1, 3,  5,  0,  0,  0,  0,  0,  0,  0,  0, 0, 0, 0, 1, 3);
    vt[19] = mk(0, 1, 0, 0,  0,  3,  0,  0,  0,  0,  0,  1,  1, 2, 0, 1, 0, 3);
    vt[20] = mk(0, 0, 0, 0,  0,  3,  0,  0,  0,  0,  0,  0,  0, 0, 0, 0, 1, 3);
    vt[21] = mk(0, 1, 1, 4,  6,  0,  0,  0,  0,  0,  0,  0,  0, 0, 0, 0, 1, 3);
    vt[22] = mk(0, 1, 0, 0,  0,  4,  4,  0,  2,  0,  0,  0,  1, 2, 2, 1, 0, 3);
    vt[23] = mk(1, 1, 0, 0,  0,  4,  4,  0,  2,  0,  0,  0,  1, 2, 2, 1, 0, 4);
    vt[24] = mk(0, 1, 0, 0,  0,  4,  4,  0,  2,  0,  0,  0,  0, 0, 0, 0, 1, 0);
    vt[25] = mk(0, 1, 1, 6,  1,  0,  0,  0,  0,  0,  0,  0,  0, 0, 0, 0, 1, 0);
    vt[26] = mk(0, 1, 0, 0,  0,  0,  6,  0,  0,  0,  0,  0,  1, 0, 2, 1, 0, 0);
    vt[27] = mk(0, 1, 1, 6,  3,  0,  6,  0,  0,  0,  0,  0,  0, 0, 1, 1, 0, 1);
    vt[28] = mk(0, 0, 0, 0,  0,  0,  6,  0,  0,  0,  0,  0,  0, 0, 2, 1, 0, 1);

    reset = 1'b1; issue_valid = 1'b0; issue_we = 1'b0; issue_rd = '0; issue_lat = '0;
    issue_rs = '0; issue_rt = '0; tuse_rs = '0; tuse_rt = '0;
    wb_valid = 1'b0; wb_rd = '0; flush = 1'b0;
    repeat (3) @(posedge clk);

    for (int i = 0; i < 29; i++) begin
      exp_t e;
      exp_t g;
      @(negedge clk);
      reset = vt[i].rst; issue_valid = vt[i].iv; issue_we = vt[i].we;
      issue_rd = vt[i].rd; issue_lat = vt[i].lat; issue_rs = vt[i].rs; issue_rt = vt[i].rt;
      tuse_rs = vt[i].trs; tuse_rt = vt[i].trt; wb_valid = vt[i].wbv; wb_rd = vt[i].wbrd;
      flush = vt[i].fl;
      e.st = vt[i].st; e.frs = vt[i].frs; e.frt = vt[i].frt;
      e.bc = vt[i].bc; e.idl = vt[i].idl; e.sc = vt[i].sc;
      q.push_back(e);
      #2;
      g = q.pop_front();
      check("stall",        i, 32'(stall),    32'(g.st));
      check("fwd_rs",       i, 32'(fwd_rs),   32'(g.frs));
      check("fwd_rt",       i, 32'(fwd_rt),   32'(g.frt));
      check("busy_cnt",     i, 32'(busy_cnt), 32'(g.bc));
      check("idle",         i, 32'(idle),     32'(g.idl));
      check("stall_cycles", i, stall_cycles,  g.sc);
    end

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
